// File: rtl/hamming_pkg.sv
// Shared types, bit positions and helpers for the SECDED correction stage.
package hamming_pkg;

  typedef logic [7:0] palabra_t;
  typedef logic [2:0] sindrome_t;
  typedef logic [3:0] dato_t;

  localparam int POS_I0 = 3;
  localparam int POS_I1 = 5;
  localparam int POS_I2 = 6;
  localparam int POS_I3 = 7;

  typedef enum logic {
    NORMAL = 1'b0,
    ALARMA = 1'b1
  } estado_t;

  // Syndrome is the bit index of the single error; 0 selects the overall parity bit p0.
  function automatic palabra_t mascara(input sindrome_t s);
    return palabra_t'(1) << s;
  endfunction

  function automatic dato_t extraer(input palabra_t w);
    return {w[POS_I3], w[POS_I2], w[POS_I1], w[POS_I0]};
  endfunction

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter: clear has priority over increment; holds at all-ones.
module contador_saturado #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/modulo_corrector_error.sv
// SECDED correction stage, 1-cycle registered output; in_ready = !out_valid | out_ready (full throughput).
// Error counters and double-error burst alarm exist only when CORRECTOR_STATS_EN is defined.
module modulo_corrector_error
  import hamming_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MAX_DOBLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  palabra_t         datos_recibidos,
  input  sindrome_t        sindrome,
  input  logic             bit_error,
  output logic             out_valid,
  input  logic             out_ready,
  output dato_t            dato_salida,
  output logic             error_simple,
  output logic             error_doble,
  output logic             alarma,
  input  logic             limpiar,
  output logic [CNT_W-1:0] cont_simples,
  output logic [CNT_W-1:0] cont_dobles
);

  localparam logic [3:0] UMBRAL = 4'(MAX_DOBLES - 1);

  logic     xfer, es_simple, es_doble;
  palabra_t corregida;

  logic  out_valid_q, out_valid_d;
  dato_t dato_q, dato_d;
  logic  simple_q, simple_d;
  logic  doble_q, doble_d;

  assign in_ready  = !out_valid_q | out_ready;
  assign xfer      = in_valid & in_ready;
  assign es_simple = bit_error;
  assign es_doble  = (sindrome != '0) & !bit_error;
  // A double error is not correctable, so the raw word is passed through untouched.
  assign corregida = es_simple ? (datos_recibidos ^ mascara(sindrome)) : datos_recibidos;

  always_comb begin
    out_valid_d = out_valid_q;
    dato_d      = dato_q;
    simple_d    = simple_q;
    doble_d     = doble_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      dato_d      = extraer(corregida);
      simple_d    = es_simple;
      doble_d     = es_doble;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dato_q      <= '0;
      simple_q    <= 1'b0;
      doble_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dato_q      <= dato_d;
      simple_q    <= simple_d;
      doble_q     <= doble_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign dato_salida  = dato_q;
  assign error_simple = simple_q;
  assign error_doble  = doble_q;

`ifdef CORRECTOR_STATS_EN
  estado_t    estado_q, estado_d;
  logic [3:0] racha_q, racha_d;

  contador_saturado #(.W(CNT_W)) u_cont_simples (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (xfer & es_simple & !limpiar),
    .clr  (limpiar),
    .q    (cont_simples)
  );

  contador_saturado #(.W(CNT_W)) u_cont_dobles (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (xfer & es_doble & !limpiar),
    .clr  (limpiar),
    .q    (cont_dobles)
  );

  // Clear wins over a simultaneous transfer; ALARMA is sticky until cleared.
  always_comb begin
    estado_d = estado_q;
    racha_d  = racha_q;
    if (limpiar) begin
      estado_d = NORMAL;
      racha_d  = '0;
    end else if (xfer && (estado_q == NORMAL)) begin
      if (es_doble) begin
        racha_d = racha_q + 4'd1;
        if (racha_q == UMBRAL) begin
          estado_d = ALARMA;
        end
      end else begin
        racha_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= NORMAL;
      racha_q  <= '0;
    end else begin
      estado_q <= estado_d;
      racha_q  <= racha_d;
    end
  end

  assign alarma = (estado_q == ALARMA);
`else
  logic unused_stats;

  assign cont_simples = '0;
  assign cont_dobles  = '0;
  assign alarma       = 1'b0;
  assign unused_stats = ^{limpiar, UMBRAL};
`endif

endmodule
